fetch_unit: RTL



---
 rtl/fetch_unit.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch front end: PC sequencing, in-order memory
//            request/response tracking, instruction FIFO, redirect flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      op,
    output logic [2:0]      f3,
    output logic [6:0]      f7
);

    localparam int                 c_CNT_W   = $clog2(DEPTH + 1);
    localparam int                 c_PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_CNT_W:0]   c_DEPTH_V = (c_CNT_W + 1)'(DEPTH);
    localparam logic [XLEN-1:0]    c_STEP    = XLEN'(4);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t              r_state_q, w_state_d;
    logic [XLEN-1:0]     r_fetch_pc_q, w_fetch_pc_d;
    logic [XLEN-1:0]     r_rsp_pc_q, w_rsp_pc_d;
    logic [c_CNT_W-1:0]  r_out_q, w_out_d;
    logic [c_CNT_W-1:0]  r_discard_q, w_discard_d;
    logic [c_CNT_W-1:0]  r_cnt_q, w_cnt_d;
    logic [c_PTR_W-1:0]  r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0]  r_rd_ptr_q, w_rd_ptr_d;
    logic [XLEN-1:0]     r_fifo_data_q [DEPTH];
    logic [XLEN-1:0]     r_fifo_pc_q   [DEPTH];

    logic                w_accept;
    logic                w_rsp_run;
    logic                w_rsp_flush;
    logic                w_push;
    logic                w_pop;
    logic [c_CNT_W:0]    w_inflight;
    logic [c_CNT_W-1:0]  w_out_after;
    logic [c_CNT_W-1:0]  w_disc_after;
    logic [c_CNT_W-1:0]  w_pending;
    logic [XLEN-1:0]     w_target;
    logic [XLEN-1:0]     w_head_data;
    logic [XLEN-1:0]     w_head_pc;
    logic                w_unused_tgt_bits;

    function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] ptr);
        if (DEPTH == 1) begin
            return '0;
        end
        return ptr + c_PTR_W'(1);
    endfunction

    assign w_target          = {redirect_target[XLEN-1:2], 2'b00};
    assign w_unused_tgt_bits = &{1'b0, redirect_target[1:0]};

    // Credit check covers both in-flight and buffered words so the FIFO can never overflow.
    assign w_inflight     = {1'b0, r_out_q} + {1'b0, r_cnt_q};
    assign imem_req_valid = (r_state_q == S_RUN) && (w_inflight < c_DEPTH_V);
    assign imem_req_addr  = r_fetch_pc_q;
    assign w_accept       = imem_req_valid && imem_req_ready;

    assign w_rsp_run   = imem_rsp_valid && (r_state_q == S_RUN) && (r_out_q != '0);
    assign w_rsp_flush = imem_rsp_valid && (r_state_q == S_FLUSH) && (r_discard_q != '0);
    assign w_push      = w_rsp_run && !redirect;

    assign inst_valid  = (r_cnt_q != '0);
    assign w_pop       = inst_valid && inst_ready;

    assign w_out_after  = r_out_q + c_CNT_W'(w_accept) - c_CNT_W'(w_rsp_run);
    assign w_disc_after = r_discard_q - c_CNT_W'(w_rsp_flush);
    assign w_pending    = w_out_after + w_disc_after;

    always_comb begin
        w_state_d    = r_state_q;
        w_fetch_pc_d = r_fetch_pc_q;
        w_rsp_pc_d   = r_rsp_pc_q;
        w_out_d      = r_out_q;
        w_discard_d  = r_discard_q;
        w_cnt_d      = r_cnt_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        w_wr_ptr_d   = r_wr_ptr_q;
        w_rd_ptr_d   = r_rd_ptr_q;

        case (r_state_q)
            S_BOOT: begin
                w_state_d = S_RUN;
            end
            S_RUN: begin
                w_out_d = w_out_after;
            end
            S_FLUSH: begin
                w_discard_d = w_disc_after;
                if (w_disc_after == '0) begin
                    w_state_d = S_RUN;
                end
            end
            default: begin
                w_state_d = S_BOOT;
            end
        endcase

        if (w_accept) begin
            w_fetch_pc_d = r_fetch_pc_q + c_STEP;
        end
        if (w_push) begin
            w_rsp_pc_d = r_rsp_pc_q + c_STEP;
            w_wr_ptr_d = f_next_ptr(r_wr_ptr_q);
        end
        if (w_pop) begin
            w_rd_ptr_d = f_next_ptr(r_rd_ptr_q);
        end

        // Everything still owed by memory becomes discard debt; buffered words are dropped.
        if (redirect) begin
            w_fetch_pc_d = w_target;
            w_rsp_pc_d   = w_target;
            w_cnt_d      = '0;
            w_wr_ptr_d   = '0;
            w_rd_ptr_d   = '0;
            w_out_d      = '0;
            w_discard_d  = w_pending;
            w_state_d    = (w_pending != '0) ? S_FLUSH : S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q    <= S_BOOT;
            r_fetch_pc_q <= RESET_PC;
            r_rsp_pc_q   <= RESET_PC;
            r_out_q      <= '0;
            r_discard_q  <= '0;
            r_cnt_q      <= '0;
            r_wr_ptr_q   <= '0;
            r_rd_ptr_q   <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_fetch_pc_q <= w_fetch_pc_d;
            r_rsp_pc_q   <= w_rsp_pc_d;
            r_out_q      <= w_out_d;
            r_discard_q  <= w_discard_d;
            r_cnt_q      <= w_cnt_d;
            r_wr_ptr_q   <= w_wr_ptr_d;
            r_rd_ptr_q   <= w_rd_ptr_d;
        end
    end

    // Storage needs no reset: its contents are only observed while the count is non-zero.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_fifo_data_q[r_wr_ptr_q] <= imem_rsp_data;
            r_fifo_pc_q[r_wr_ptr_q]   <= r_rsp_pc_q;
        end
    end

    assign w_head_data = r_fifo_data_q[r_rd_ptr_q];
    assign w_head_pc   = r_fifo_pc_q[r_rd_ptr_q];

    assign inst    = inst_valid ? w_head_data : '0;
    assign inst_pc = inst_valid ? w_head_pc   : '0;
    assign op      = inst[6:0];
    assign f3      = inst[14:12];
    assign f7      = inst[31:25];

endmodule
`default_nettype wire
